// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and helpers for the keypad scanner
//
// Purpose : FSM state encoding, matrix dimensions, key index type, and two
//           small helpers (lowest active row, column drive pattern).
// Ports   : none (package).

package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} scan_state_t;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef logic [1:0] key_idx_t;

   // Lowest-index row that is pulled low; rows are active low.
   function automatic key_idx_t lowest_low(input logic [NUM_ROWS-1:0] r);
      key_idx_t idx;
      idx = '0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!r[i]) idx = key_idx_t'(i);
      end
      return idx;
   endfunction

   // One column low, the rest high.
   function automatic logic [NUM_COLS-1:0] col_drive(input key_idx_t c);
      logic [NUM_COLS-1:0] one;
      one = NUM_COLS'(1);
      return ~(one << c);
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key report signal bundle
//
// Purpose : groups the keypad matrix lines and the key report outputs.
// Signals : rows (in to scanner, active low), cols (column drives),
//           row_index/col_index (last accepted key), key_valid (one-cycle
//           strobe per accepted press), key_held (press accepted, not yet
//           released).
// Modports: master = scanner side, slave = keypad/consumer side.

interface keypad_scanner_if;
   import keypad_pkg::*;

   logic [NUM_ROWS-1:0] rows;
   logic [NUM_COLS-1:0] cols;
   key_idx_t            row_index;
   key_idx_t            col_index;
   logic                key_valid;
   logic                key_held;

   modport master (
      input  rows,
      output cols, row_index, col_index, key_valid, key_held
   );

   modport slave (
      output rows,
      input  cols, row_index, col_index, key_valid, key_held
   );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all ones
//
// Purpose : brings asynchronous level inputs into the clk domain.
// Ports   : clk, nreset (async active low), d (async input), q (synced output).
// Reset value is all ones so that idle pulled-up lines read as inactive.

module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low matrix keypad scanner with debounce
//
// Purpose : drives one column low at a time, samples the rows at the end of
//           each column dwell, debounces press and release of the first key
//           found, and reports it once per press.
// Ports   : clk, nreset (async active low), bus (keypad_scanner_if.master:
//           rows in, cols / row_index / col_index / key_valid / key_held out).
// Params  : SCAN_DIV        - cycles each column is driven before sampling.
//           DEBOUNCE_CYCLES - cycles a row level must hold to be accepted.

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4800,
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input  logic              clk,
   input  logic              nreset,
   keypad_scanner_if.master  bus
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_ROWS-1:0] rows_s;

   scan_state_t   state, state_next;
   logic [SW-1:0] scan_cnt, scan_cnt_next;
   logic [DW-1:0] deb_cnt, deb_cnt_next;
   key_idx_t      col_sel, col_sel_next;
   key_idx_t      lat_row, lat_row_next;
   key_idx_t      row_index_q, row_index_next;
   key_idx_t      col_index_q, col_index_next;
   logic          key_valid_q, key_valid_next;
   logic          key_held_q, key_held_next;
   logic          row_lvl;

   sync_2ff #(.WIDTH(NUM_ROWS)) u_rows_sync (
      .clk    (clk),
      .nreset (nreset),
      .d      (bus.rows),
      .q      (rows_s)
   );

   // Once a key is latched only its own row matters; col_sel stays frozen
   // so that row line is still connected to the same key.
   assign row_lvl = rows_s[lat_row];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state       <= SCAN;
         scan_cnt    <= '0;
         deb_cnt     <= '0;
         col_sel     <= '0;
         lat_row     <= '0;
         row_index_q <= '0;
         col_index_q <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state       <= state_next;
         scan_cnt    <= scan_cnt_next;
         deb_cnt     <= deb_cnt_next;
         col_sel     <= col_sel_next;
         lat_row     <= lat_row_next;
         row_index_q <= row_index_next;
         col_index_q <= col_index_next;
         key_valid_q <= key_valid_next;
         key_held_q  <= key_held_next;
      end
   end

   always_comb begin
      state_next     = state;
      scan_cnt_next  = scan_cnt;
      deb_cnt_next   = deb_cnt;
      col_sel_next   = col_sel;
      lat_row_next   = lat_row;
      row_index_next = row_index_q;
      col_index_next = col_index_q;
      key_valid_next = 1'b0;
      key_held_next  = key_held_q;

      case (state)
         SCAN: begin
            if (scan_cnt == SCAN_LAST) begin
               scan_cnt_next = '0;
               if (rows_s != '1) begin
                  lat_row_next = lowest_low(rows_s);
                  deb_cnt_next = '0;
                  state_next   = DEB_PRESS;
               end else begin
                  col_sel_next = col_sel + 1'b1;
               end
            end else begin
               scan_cnt_next = scan_cnt + 1'b1;
            end
         end

         DEB_PRESS: begin
            if (row_lvl) begin
               // Bounce: rescan the same column from a fresh dwell.
               scan_cnt_next = '0;
               state_next    = SCAN;
            end else if (deb_cnt == DEB_LAST) begin
               key_valid_next = 1'b1;
               row_index_next = lat_row;
               col_index_next = col_sel;
               key_held_next  = 1'b1;
               deb_cnt_next   = '0;
               state_next     = HELD;
            end else begin
               deb_cnt_next = deb_cnt + 1'b1;
            end
         end

         HELD: begin
            if (row_lvl) begin
               deb_cnt_next = '0;
               state_next   = DEB_REL;
            end
         end

         DEB_REL: begin
            if (!row_lvl) begin
               state_next = HELD;
            end else if (deb_cnt == DEB_LAST) begin
               key_held_next = 1'b0;
               col_sel_next  = col_sel + 1'b1;
               scan_cnt_next = '0;
               state_next    = SCAN;
            end else begin
               deb_cnt_next = deb_cnt + 1'b1;
            end
         end

         default: state_next = SCAN;
      endcase
   end

   assign bus.cols      = col_drive(col_sel);
   assign bus.row_index = row_index_q;
   assign bus.col_index = col_index_q;
   assign bus.key_valid = key_valid_q;
   assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner

module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int PRESS_BUDGET = 4 * SCAN_DIV + 2 + DEB + 1 + 40;
   localparam int REL_BUDGET   = DEB + 12;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic [3:0][3:0] pressed = '0;   // [row][col], 1 = key physically closed

   int tests = 0;
   int fails = 0;

   keypad_scanner_if bus ();

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Physical keypad: a row is pulled low when a closed key connects it to
   // a column that is currently driven low.
   function automatic logic [3:0] matrix_rows(input logic [3:0][3:0] p, input logic [3:0] c);
      logic [3:0] r;
      r = 4'b1111;
      for (int i = 0; i < 4; i++) if (|(p[i] & ~c)) r[i] = 1'b0;
      return r;
   endfunction

   assign bus.rows = matrix_rows(pressed, bus.cols);

   // Expected key from the scan rules: first column in scan order starting
   // at start_col that has any closed key, lowest row within that column.
   function automatic logic [3:0] first_key(input logic [3:0][3:0] p, input int start_col);
      int c;
      for (int k = 0; k < 4; k++) begin
         c = (start_col + k) % 4;
         for (int r = 0; r < 4; r++) if (p[r][c]) return {2'(r), 2'(c)};
      end
      return 4'hF;
   endfunction

   function automatic logic [3:0] exp_cols(input int c);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << c);
   endfunction

   // Monitor: counts strobes and records reported key; flags index changes
   // that happen without a strobe outside reset.
   int pulses = 0;
   int idx_glitches = 0;
   key_idx_t seen_r = '0, seen_c = '0, prev_r = '0, prev_c = '0;
   always @(negedge clk) begin
      if (bus.key_valid) begin
         pulses++;
         seen_r = bus.row_index;
         seen_c = bus.col_index;
      end else if (nreset && (bus.row_index !== prev_r || bus.col_index !== prev_c)) begin
         idx_glitches++;
      end
      prev_r = bus.row_index;
      prev_c = bus.col_index;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pulse(input string tag, input int p0);
      int n;
      n = 0;
      while (pulses == p0 && n < PRESS_BUDGET) begin cyc(); n++; end
      cyc();
      check({tag, "_pulse"}, 32'(pulses - p0), 32'd1);
   endtask

   task automatic wait_release(input string tag);
      int n;
      n = 0;
      while (bus.key_held && n < REL_BUDGET) begin cyc(); n++; end
      check({tag, "_released"}, 32'(bus.key_held), 32'd0);
   endtask

   task automatic check_key(input string tag, input logic [3:0] exp_key);
      check({tag, "_row"}, 32'(seen_r), 32'(exp_key[3:2]));
      check({tag, "_col"}, 32'(seen_c), 32'(exp_key[1:0]));
      check({tag, "_row_out"}, 32'(bus.row_index), 32'(exp_key[3:2]));
      check({tag, "_col_out"}, 32'(bus.col_index), 32'(exp_key[1:0]));
      check({tag, "_held"}, 32'(bus.key_held), 32'd1);
   endtask

   initial begin
      int p0, n, r, c, nb;
      logic [3:0] ek;

      // Reset state
      repeat (3) cyc();
      check("rst_cols", 32'(bus.cols), 32'h0E);
      check("rst_row_index", 32'(bus.row_index), 32'd0);
      check("rst_col_index", 32'(bus.col_index), 32'd0);
      check("rst_key_valid", 32'(bus.key_valid), 32'd0);
      check("rst_key_held", 32'(bus.key_held), 32'd0);

      // Idle scan rotation: after k clocks the column is (k / SCAN_DIV) % 4
      nreset = 1'b1;
      p0 = pulses;
      for (int k = 0; k < 64; k++) begin
         check("idle_cols", 32'(bus.cols), 32'(exp_cols((k / SCAN_DIV) % 4)));
         cyc();
      end
      check("idle_no_pulse", 32'(pulses - p0), 32'd0);

      // Row 2 / col 1 held steady; cols frozen while held
      p0 = pulses;
      pressed[2][1] = 1'b1;
      wait_pulse("k21", p0);
      check_key("k21", {2'd2, 2'd1});
      for (int k = 0; k < 20; k++) begin
         check("k21_cols_frozen", 32'(bus.cols), 32'h0D);
         cyc();
      end
      pressed = '0;
      wait_release("k21");
      check("k21_single", 32'(pulses - p0), 32'd1);

      // Row 0 / col 3 bouncing with 3-cycle phases, then steady
      p0 = pulses;
      repeat (10) begin
         pressed[0][3] = 1'b1; repeat (3) cyc();
         pressed[0][3] = 1'b0; repeat (3) cyc();
      end
      check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
      pressed[0][3] = 1'b1;
      wait_pulse("k03", p0);
      check_key("k03", {2'd0, 2'd3});
      pressed = '0;
      wait_release("k03");

      // Hold (1,0), add (3,2): ignored until (1,0) released, then reported
      p0 = pulses;
      pressed[1][0] = 1'b1;
      wait_pulse("k10", p0);
      check_key("k10", {2'd1, 2'd0});
      pressed[3][2] = 1'b1;
      repeat (30) cyc();
      check("k10_second_ignored", 32'(pulses - p0), 32'd1);
      check("k10_cols_frozen", 32'(bus.cols), 32'h0E);
      pressed[1][0] = 1'b0;
      wait_release("k10");
      wait_pulse("k32", p0 + 1);
      check_key("k32", first_key(pressed, 1));
      pressed = '0;
      wait_release("k32");

      // Rows 1 and 3 on col 0 together: lowest row wins
      p0 = pulses;
      pressed[1][0] = 1'b1;
      pressed[3][0] = 1'b1;
      wait_pulse("k1_3", p0);
      check_key("k1_3", first_key(pressed, 0));
      pressed = '0;
      wait_release("k1_3");

      // Reset during press debounce
      n = 0;
      while (bus.cols == 4'b1011 && n < 20) begin cyc(); n++; end
      n = 0;
      while (bus.cols != 4'b1011 && n < 20) begin cyc(); n++; end
      check("rstmid_reach_col2", 32'(bus.cols), 32'h0B);
      p0 = pulses;
      pressed[2][2] = 1'b1;
      repeat (7) cyc();
      nreset = 1'b0;
      #1;
      check("rstmid_cols", 32'(bus.cols), 32'h0E);
      check("rstmid_row_index", 32'(bus.row_index), 32'd0);
      check("rstmid_col_index", 32'(bus.col_index), 32'd0);
      check("rstmid_key_valid", 32'(bus.key_valid), 32'd0);
      check("rstmid_key_held", 32'(bus.key_held), 32'd0);
      pressed = '0;
      repeat (3) cyc();
      nreset = 1'b1;
      for (int k = 0; k < 2 * SCAN_DIV; k++) begin
         check("rstmid_restart_cols", 32'(bus.cols), 32'(exp_cols(k / SCAN_DIV)));
         cyc();
      end
      repeat (DEB + 4) cyc();
      check("rstmid_no_pulse", 32'(pulses - p0), 32'd0);

      // Randomized single keys with press and release bounces
      for (int it = 0; it < 8; it++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         p0 = pulses;
         nb = $urandom_range(0, 3);
         repeat (nb) begin
            pressed[r][c] = 1'b1; repeat ($urandom_range(1, 5)) cyc();
            pressed[r][c] = 1'b0; repeat ($urandom_range(1, 5)) cyc();
         end
         check("rnd_bounce_no_pulse", 32'(pulses - p0), 32'd0);
         pressed[r][c] = 1'b1;
         ek = first_key(pressed, 0);
         wait_pulse("rnd", p0);
         check_key("rnd", ek);
         check("rnd_cols_frozen", 32'(bus.cols), 32'(exp_cols(c)));
         nb = $urandom_range(0, 3);
         repeat (nb) begin
            pressed[r][c] = 1'b0; repeat ($urandom_range(1, 5)) cyc();
            pressed[r][c] = 1'b1; repeat ($urandom_range(1, 5)) cyc();
         end
         check("rnd_still_held", 32'(bus.key_held), 32'd1);
         pressed = '0;
         wait_release("rnd");
         check("rnd_single", 32'(pulses - p0), 32'd1);
      end

      check("idx_only_with_valid", 32'(idx_glitches), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
